// File: rtl/vector_checker16_pkg.sv
// Shared definitions for the vector checker: checker state encodings and default widths.
// The stimulus-driver block imports the same package so both ends agree on encodings.
package vector_checker16_pkg;

    localparam int CHK_WIDTH_DEF = 16;
    localparam int CHK_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_RUN   = 2'd1,
        CHK_DRAIN = 2'd2,
        CHK_DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/vector_checker16_if.sv
// Test-vector bus between a stimulus driver (master) and the response checker (slave).
interface vector_checker16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             last;
    logic [WIDTH-1:0] dut_out;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] mask;

    modport master (
        output in_valid, last, dut_out, expected, mask,
        input  in_ready
    );

    modport slave (
        input  in_valid, last, dut_out, expected, mask,
        output in_ready
    );
endinterface

// File: rtl/vector_checker16_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count register: clear wins over increment, increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/vector_checker16.sv
// Response checker: compares DUT results against golden values under a mask, counts
// vectors and mismatches, captures the first failure and issues a pass/fail verdict.
//
// state     | meaning
// ----------+----------------------------------------------------------
// CHK_IDLE  | after reset, waiting for start
// CHK_RUN   | accepting vectors (in_ready=1)
// CHK_DRAIN | last vector is in the compare stage, one cycle
// CHK_DONE  | verdict valid, held until start
module vector_checker16
    import vector_checker16_pkg::*;
#(
    parameter int WIDTH = CHK_WIDTH_DEF,
    parameter int CNT_W = CHK_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    vector_checker16_if.slave   vec,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    vec_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    first_fail_idx,
    output logic [WIDTH-1:0]    first_fail_diff
);

    chk_state_t state;
    chk_state_t state_nxt;

    logic             accept;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_diff;
    logic [CNT_W-1:0] s1_idx;
    logic             s1_fail;
    logic             err_inc;

    assign vec.in_ready = (state == CHK_RUN);

    // A vector arriving together with start belongs to the run being discarded.
    assign accept  = vec.in_valid && vec.in_ready && !start;
    assign s1_fail = s1_valid && (s1_diff != '0);
    assign err_inc = s1_fail && !start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CHK_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start restarts a run from any state.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = CHK_RUN;
        end else begin
            case (state)
                CHK_RUN:   if (accept && vec.last) state_nxt = CHK_DRAIN;
                CHK_DRAIN: state_nxt = CHK_DONE;
                default:   state_nxt = state;
            endcase
        end
    end

    // Stage 1: capture the masked difference and the vector's index on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_idx   <= '0;
        end else if (start) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff <= (vec.dut_out ^ vec.expected) & vec.mask;
                s1_idx  <= vec_count;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (accept),
        .q     (vec_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (err_inc),
        .q     (err_count)
    );

    // Stage 2: latch the first failure of the run; the error counter never returns to
    // zero within a run, so err_count==0 identifies the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_idx  <= '0;
            first_fail_diff <= '0;
        end else if (start) begin
            first_fail_idx  <= '0;
            first_fail_diff <= '0;
        end else if (s1_fail && (err_count == '0)) begin
            first_fail_idx  <= s1_idx;
            first_fail_diff <= s1_diff;
        end
    end

    // Verdict: registered on the DRAIN edge, folding in the last vector's compare result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (start) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (state == CHK_DRAIN) begin
            done <= 1'b1;
            pass <= (err_count == '0) && !s1_fail;
        end
    end

endmodule

// File: tb/tb_vector_checker16.sv
// Bench for vector_checker16: directed scenarios plus randomized runs, all checked
// against a queue-based reference model of the run's expected counts and verdict.
module tb_vector_checker16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;

    logic        done, pass, done2, pass2;
    logic [7:0]  vec_count, err_count, first_fail_idx;
    logic [15:0] first_fail_diff, first_fail_diff2;
    logic [1:0]  vec_count2, err_count2, first_fail_idx2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] e;
        logic [15:0] m;
    } vec_t;

    vec_t vq[$];

    int          m_vec, m_err, m_idx, m_err_pre;
    logic [15:0] m_diff;
    logic        m_pass;

    vector_checker16_if #(.WIDTH(16)) bus ();
    vector_checker16_if #(.WIDTH(16)) bus2 ();

    always #5 clk = ~clk;

    vector_checker16 #(.WIDTH(16), .CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vec             (bus),
        .done            (done),
        .pass            (pass),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .first_fail_idx  (first_fail_idx),
        .first_fail_diff (first_fail_diff)
    );

    vector_checker16 #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start2),
        .vec             (bus2),
        .done            (done2),
        .pass            (pass2),
        .vec_count       (vec_count2),
        .err_count       (err_count2),
        .first_fail_idx  (first_fail_idx2),
        .first_fail_diff (first_fail_diff2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what a run over the queued vectors must report, with counters
    // clamped at cmax and the failure index taken from the clamped vector count.
    task automatic model(input int cmax);
        logic [15:0] dv;
        m_vec = 0; m_err = 0; m_idx = 0; m_diff = '0; m_err_pre = 0;
        foreach (vq[i]) begin
            dv = (vq[i].d ^ vq[i].e) & vq[i].m;
            if (dv != 16'h0) begin
                if (m_err == 0) begin
                    m_idx  = (i > cmax) ? cmax : i;
                    m_diff = dv;
                end
                m_err++;
                if (i != vq.size() - 1) m_err_pre++;
            end
        end
        m_vec     = (vq.size() > cmax) ? cmax : vq.size();
        m_pass    = (m_err == 0);
        m_err     = (m_err > cmax) ? cmax : m_err;
        m_err_pre = (m_err_pre > cmax) ? cmax : m_err_pre;
    endtask

    task automatic idle_bus();
        bus.in_valid = 1'b0;
        bus.last     = 1'b0;
        bus.dut_out  = 16'($urandom);
        bus.expected = 16'($urandom);
        bus.mask     = 16'($urandom);
    endtask

    // Called just after a falling edge; returns one clock later, just after the next fall.
    task automatic send(input vec_t v, input logic lst);
        bus.in_valid = 1'b1;
        bus.last     = lst;
        bus.dut_out  = v.d;
        bus.expected = v.e;
        bus.mask     = v.m;
        @(negedge clk);
        idle_bus();
    endtask

    // Start pulse with a mismatching last vector presented alongside; it must be ignored.
    task automatic do_start();
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.last     = 1'b1;
        bus.dut_out  = 16'h1234;
        bus.expected = 16'hEDCB;
        bus.mask     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        idle_bus();
    endtask

    task automatic run_q(input string tag, input bit gaps);
        vec_t v;
        model(255);
        do_start();
        chk({tag, ".ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, ".vec0"}, 32'(vec_count), 32'd0);
        for (int i = 0; i < vq.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
            v = vq[i];
            send(v, i == vq.size() - 1);
        end
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        chk({tag, ".ready_drain"}, 32'(bus.in_ready), 32'd0);
        chk({tag, ".err_pre"}, 32'(err_count), 32'(m_err_pre));
        @(negedge clk);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".pass"}, 32'(pass), 32'(m_pass));
        chk({tag, ".vec"}, 32'(vec_count), 32'(m_vec));
        chk({tag, ".err"}, 32'(err_count), 32'(m_err));
        chk({tag, ".fidx"}, 32'(first_fail_idx), 32'(m_idx));
        chk({tag, ".fdiff"}, 32'(first_fail_diff), 32'(m_diff));
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.e = 16'($urandom);
        v.d = ($urandom_range(0, 1) == 0) ? v.e : (v.e ^ 16'($urandom));
        case ($urandom_range(0, 7))
            0:       v.m = 16'h0000;
            1:       v.m = 16'hFFFF;
            default: v.m = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int n;
        vec_t v;
        idle_bus();
        bus2.in_valid = 1'b0; bus2.last = 1'b0;
        bus2.dut_out = '0; bus2.expected = '0; bus2.mask = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready", 32'(bus.in_ready), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.vec", 32'(vec_count), 32'd0);

        // Mid-run reset: asynchronous clear back to idle values.
        do_start();
        v = '{d: 16'h0001, e: 16'h0000, m: 16'hFFFF};
        send(v, 1'b0);
        send(v, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.vec", 32'(vec_count), 32'd0);
        chk("midrst.err", 32'(err_count), 32'd0);
        chk("midrst.fdiff", 32'(first_fail_diff), 32'd0);
        chk("midrst.ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.idle_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.pass", 32'(pass), 32'd0);

        // All-match run.
        vq = {};
        vq.push_back('{d: 16'h0000, e: 16'h0000, m: 16'hFFFF});
        vq.push_back('{d: 16'hAAAA & 16'h5555, e: 16'h0000, m: 16'hFFFF});
        vq.push_back('{d: 16'h3C03 & 16'h0FF0, e: 16'h0C00, m: 16'hFFFF});
        run_q("t2", 1'b0);
        chk("t2.pass_c", 32'(pass), 32'd1);
        chk("t2.vec_c", 32'(vec_count), 32'd3);

        // Two failures; first at index 1.
        vq = {};
        vq.push_back('{d: 16'h0000, e: 16'h0000, m: 16'hFFFF});
        vq.push_back('{d: 16'h1034, e: 16'h1030, m: 16'hFFFF});
        vq.push_back('{d: 16'h0000, e: 16'hFFFF, m: 16'hFFFF});
        run_q("t3", 1'b0);
        chk("t3.err_c", 32'(err_count), 32'd2);
        chk("t3.fidx_c", 32'(first_fail_idx), 32'd1);
        chk("t3.fdiff_c", 32'(first_fail_diff), 32'h0004);

        // Masked-out difference.
        vq[1].m = 16'hFFFB;
        run_q("t4", 1'b0);
        chk("t4.err_c", 32'(err_count), 32'd1);
        chk("t4.fidx_c", 32'(first_fail_idx), 32'd2);
        chk("t4.fdiff_c", 32'(first_fail_diff), 32'hFFFF);

        // Start right after a failing accept discards the failure; start-cycle vector ignored.
        do_start();
        v = '{d: 16'hFFFF, e: 16'h0000, m: 16'hFFFF};
        send(v, 1'b0);
        do_start();
        chk("t6.err", 32'(err_count), 32'd0);
        chk("t6.vec", 32'(vec_count), 32'd0);
        chk("t6.ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("t6.err_late", 32'(err_count), 32'd0);
        v = '{d: 16'h5A5A, e: 16'h5A5A, m: 16'hFFFF};
        send(v, 1'b1);
        @(negedge clk);
        chk("t6.done", 32'(done), 32'd1);
        chk("t6.pass", 32'(pass), 32'd1);
        chk("t6.vec1", 32'(vec_count), 32'd1);
        bus.in_valid = 1'b1; bus.last = 1'b1;
        bus.dut_out = 16'h0F0F; bus.expected = 16'hF0F0; bus.mask = 16'hFFFF;
        repeat (4) @(negedge clk);
        idle_bus();
        chk("t6.done_hold", 32'(done), 32'd1);
        chk("t6.vec_hold", 32'(vec_count), 32'd1);
        chk("t6.err_hold", 32'(err_count), 32'd0);

        // Narrow-counter instance: counters saturate at 3.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.last     = (i == 4);
            bus2.expected = 16'(i);
            bus2.dut_out  = ~16'(i);
            bus2.mask     = 16'hFFFF;
            @(negedge clk);
        end
        bus2.in_valid = 1'b0; bus2.last = 1'b0;
        @(negedge clk);
        chk("t5.done", 32'(done2), 32'd1);
        chk("t5.vec", 32'(vec_count2), 32'd3);
        chk("t5.err", 32'(err_count2), 32'd3);
        chk("t5.fidx", 32'(first_fail_idx2), 32'd0);
        chk("t5.fdiff", 32'(first_fail_diff2), 32'hFFFF);
        chk("t5.pass", 32'(pass2), 32'd0);

        // Randomized runs, including one long enough to saturate the 8-bit counters.
        for (int r = 0; r < 12; r++) begin
            vq = {};
            n = (r == 11) ? 300 : $urandom_range(1, 20);
            for (int i = 0; i < n; i++) vq.push_back(rand_vec());
            run_q($sformatf("rnd%0d", r), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
